// File: rtl/issue_scheduler_pkg.sv
// issue_scheduler_pkg: opcodes, FSM states and issue classes shared by the issue scheduler
package issue_scheduler_pkg;
  localparam logic [6:0] LUI     = 7'b0110111;
  localparam logic [6:0] AUIPC   = 7'b0010111;
  localparam logic [6:0] JAL     = 7'b1101111;
  localparam logic [6:0] JALR    = 7'b1100111;
  localparam logic [6:0] B_TYPE  = 7'b1100011;
  localparam logic [6:0] LD_TYPE = 7'b0000011;
  localparam logic [6:0] S_TYPE  = 7'b0100011;
  localparam logic [6:0] I_TYPE  = 7'b0010011;
  localparam logic [6:0] R_TYPE  = 7'b0110011;
  localparam int ROB_SIZE_WIDTH = 3;
  typedef enum logic [1:0] {RUN, JALR_WAIT, FLUSH} state_t;
  typedef enum logic [1:0] {CLS_ROB, CLS_RS, CLS_LSB} cls_t;
  function automatic cls_t classify(input logic [6:0] op);
    return (op == LD_TYPE || op == S_TYPE) ? CLS_LSB :
           (op == LUI || op == AUIPC || op == JAL) ? CLS_ROB : CLS_RS;
  endfunction
endpackage

// File: rtl/issue_scheduler_credit_counter.sv
// issue_scheduler_credit_counter: free-entry credit counter with take/give/reload
module issue_scheduler_credit_counter #(
  parameter int DEPTH = 8,
  parameter int W = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         take,
  input  logic         give,
  input  logic         reload,
  output logic [W-1:0] free,
  output logic         nonzero
);
  localparam logic [W-1:0] FULL = W'(DEPTH);
  logic [W-1:0] free_q, free_d;
  // take and give in one cycle cancel; a give at FULL saturates
  always_comb begin
    free_d = !en ? free_q :
             reload ? FULL :
             (take && !give) ? free_q - 1'b1 :
             (give && !take && free_q != FULL) ? free_q + 1'b1 : free_q;
  end
  // credit register; a release with every entry already free is a protocol error
  always_ff @(posedge clk) begin
    if (rst) free_q <= FULL;
    else free_q <= free_d;
    if (!rst && en && !reload && give && !take)
      assert (free_q != FULL) else $error("credit released while already full");
  end
  assign free = free_q;
  assign nonzero = free_q != '0;
endmodule

// File: rtl/issue_scheduler.sv
// issue_scheduler: credit-based issue of decoded instructions into RoB/RS/LSB
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int ROB_DEPTH = 8,
  parameter int RS_DEPTH  = 8,
  parameter int LSB_DEPTH = 8,
  parameter int ROB_W     = $clog2(ROB_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [6:0]       in_type,
  input  logic             in_dep1,
  output logic             in_ready,
  output logic             issue_valid,
  output logic             issue_to_rs,
  output logic             issue_to_lsb,
  output logic [ROB_W-1:0] issue_rob_id,
  input  logic             rob_release,
  input  logic             rs_release,
  input  logic             lsb_release,
  output logic             fetch_stall
);
  state_t state_q, state_d;
  cls_t cls;
  logic [ROB_W-1:0] tail_q, tail_d, issue_rob_id_q, issue_rob_id_d;
  logic issue_valid_q, issue_valid_d, issue_to_rs_q, issue_to_rs_d, issue_to_lsb_q, issue_to_lsb_d;
  logic jalr_block, need_ok, fire, flush, rob_nz, rs_nz, lsb_nz;
  logic [$clog2(ROB_DEPTH):0] unused_rob_free;
  logic [$clog2(RS_DEPTH):0] unused_rs_free;
  logic [$clog2(LSB_DEPTH):0] unused_lsb_free;
  // accept decision, FSM next state and issue register next values
  always_comb begin
    cls = classify(in_type);
    jalr_block = in_type == JALR && in_dep1;
    need_ok = rob_nz && (cls != CLS_RS || rs_nz) && (cls != CLS_LSB || lsb_nz);
    in_ready = rdy && !clear && state_q == RUN && need_ok && !jalr_block;
    fire = in_valid && in_ready;
    flush = rdy && state_q == FLUSH;
    state_d = !rdy ? state_q :
              clear ? FLUSH :
              (state_q == RUN && in_valid && jalr_block) ? JALR_WAIT :
              ((state_q == JALR_WAIT && !in_dep1) || state_q == FLUSH) ? RUN : state_q;
    tail_d = flush ? '0 : fire ? tail_q + 1'b1 : tail_q;
    issue_valid_d = rdy ? fire : issue_valid_q;
    issue_to_rs_d = rdy ? fire && cls == CLS_RS : issue_to_rs_q;
    issue_to_lsb_d = rdy ? fire && cls == CLS_LSB : issue_to_lsb_q;
    issue_rob_id_d = fire ? tail_q : issue_rob_id_q;
  end
  // state, tail and registered issue outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      tail_q <= '0;
      issue_valid_q <= 1'b0;
      issue_to_rs_q <= 1'b0;
      issue_to_lsb_q <= 1'b0;
      issue_rob_id_q <= '0;
    end else begin
      state_q <= state_d;
      tail_q <= tail_d;
      issue_valid_q <= issue_valid_d;
      issue_to_rs_q <= issue_to_rs_d;
      issue_to_lsb_q <= issue_to_lsb_d;
      issue_rob_id_q <= issue_rob_id_d;
    end
  end
  issue_scheduler_credit_counter #(.DEPTH(ROB_DEPTH)) u_rob (
    .clk(clk), .rst(rst), .en(rdy), .take(fire), .give(rob_release), .reload(flush),
    .free(unused_rob_free), .nonzero(rob_nz));
  issue_scheduler_credit_counter #(.DEPTH(RS_DEPTH)) u_rs (
    .clk(clk), .rst(rst), .en(rdy), .take(fire && cls == CLS_RS), .give(rs_release), .reload(flush),
    .free(unused_rs_free), .nonzero(rs_nz));
  issue_scheduler_credit_counter #(.DEPTH(LSB_DEPTH)) u_lsb (
    .clk(clk), .rst(rst), .en(rdy), .take(fire && cls == CLS_LSB), .give(lsb_release), .reload(flush),
    .free(unused_lsb_free), .nonzero(lsb_nz));
  assign issue_valid = issue_valid_q;
  assign issue_to_rs = issue_to_rs_q;
  assign issue_to_lsb = issue_to_lsb_q;
  assign issue_rob_id = issue_rob_id_q;
  assign fetch_stall = state_q != RUN;
endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: directed scenario tests for issue_scheduler
module tb_issue_scheduler;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  logic clk = 0, rst = 1, rdy = 1, clear = 0, in_valid = 0, in_dep1 = 0;
  logic [6:0] in_type = OP_ADDI;
  logic rob_release = 0, rs_release = 0, lsb_release = 0;
  logic in_ready, issue_valid, issue_to_rs, issue_to_lsb, fetch_stall;
  logic [2:0] issue_rob_id;
  int checks = 0, errors = 0;
  issue_scheduler dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .in_valid(in_valid), .in_type(in_type),
    .in_dep1(in_dep1), .in_ready(in_ready), .issue_valid(issue_valid), .issue_to_rs(issue_to_rs),
    .issue_to_lsb(issue_to_lsb), .issue_rob_id(issue_rob_id), .rob_release(rob_release),
    .rs_release(rs_release), .lsb_release(lsb_release), .fetch_stall(fetch_stall));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1; rdy = 1; clear = 0; in_valid = 0; in_dep1 = 0; in_type = OP_ADDI;
    rob_release = 0; rs_release = 0; lsb_release = 0;
    tick(); tick();
    rst = 0;
  endtask
  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", issue_valid); end
    checks++; if (issue_to_rs !== 1'b0) begin errors++; $display("FAIL reset_to_rs got %b exp 0", issue_to_rs); end
    checks++; if (issue_to_lsb !== 1'b0) begin errors++; $display("FAIL reset_to_lsb got %b exp 0", issue_to_lsb); end
    checks++; if (issue_rob_id !== 3'd0) begin errors++; $display("FAIL reset_rob_id got %0d exp 0", issue_rob_id); end
    checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", fetch_stall); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", in_ready); end
  endtask
  task automatic test_fill_rs();
    do_reset();
    in_valid = 1; in_type = OP_ADDI;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d got %b exp 1", i, in_ready); end
      tick();
      checks++; if (issue_valid !== 1'b1 || issue_to_rs !== 1'b1 || issue_rob_id !== 3'(i))
        begin errors++; $display("FAIL fill_issue%0d got v=%b rs=%b id=%0d exp v=1 rs=1 id=%0d", i, issue_valid, issue_to_rs, issue_rob_id, i); end
    end
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got %b exp 0", in_ready); end
    tick();
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL fill_no_issue got %b exp 0", issue_valid); end
    in_valid = 0;
  endtask
  task automatic test_lsb();
    do_reset();
    in_valid = 1; in_type = OP_LD; rob_release = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (issue_valid !== 1'b1 || issue_to_lsb !== 1'b1 || issue_to_rs !== 1'b0 || issue_rob_id !== 3'(i))
        begin errors++; $display("FAIL lsb_issue%0d got v=%b lsb=%b rs=%b id=%0d exp v=1 lsb=1 rs=0 id=%0d", i, issue_valid, issue_to_lsb, issue_to_rs, issue_rob_id, i); end
    end
    rob_release = 0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lsb_full_ready got %b exp 0", in_ready); end
    in_type = OP_ADD;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lsb_add_ready got %b exp 1", in_ready); end
    tick();
    checks++; if (issue_valid !== 1'b1 || issue_to_rs !== 1'b1 || issue_to_lsb !== 1'b0 || issue_rob_id !== 3'd0)
      begin errors++; $display("FAIL lsb_add_issue got v=%b rs=%b lsb=%b id=%0d exp v=1 rs=1 lsb=0 id=0", issue_valid, issue_to_rs, issue_to_lsb, issue_rob_id); end
    in_type = OP_LD;
    tick();
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL lsb_stall got %b exp 0", issue_valid); end
    lsb_release = 1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lsb_release_same_cycle got %b exp 0", in_ready); end
    tick();
    lsb_release = 0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lsb_release_ready got %b exp 1", in_ready); end
    tick();
    checks++; if (issue_valid !== 1'b1 || issue_to_lsb !== 1'b1 || issue_rob_id !== 3'd1)
      begin errors++; $display("FAIL lsb_ninth got v=%b lsb=%b id=%0d exp v=1 lsb=1 id=1", issue_valid, issue_to_lsb, issue_rob_id); end
    in_valid = 0;
  endtask
  task automatic test_jalr();
    do_reset();
    in_valid = 1; in_type = OP_JALR; in_dep1 = 1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL jalr_ready got %b exp 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (fetch_stall !== 1'b1 || issue_valid !== 1'b0)
        begin errors++; $display("FAIL jalr_wait%0d got stall=%b v=%b exp stall=1 v=0", i, fetch_stall, issue_valid); end
    end
    in_dep1 = 0;
    tick();
    checks++; if (fetch_stall !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL jalr_resume got stall=%b ready=%b exp stall=0 ready=1", fetch_stall, in_ready); end
    tick();
    checks++; if (issue_valid !== 1'b1 || issue_to_rs !== 1'b1 || issue_rob_id !== 3'd0 || fetch_stall !== 1'b0)
      begin errors++; $display("FAIL jalr_issue got v=%b rs=%b id=%0d stall=%b exp v=1 rs=1 id=0 stall=0", issue_valid, issue_to_rs, issue_rob_id, fetch_stall); end
    in_valid = 0;
    in_type = OP_JALR; in_dep1 = 1; in_valid = 1;
    tick();
    rst = 1;
    tick();
    rst = 0; in_valid = 0; in_dep1 = 0;
    checks++; if (fetch_stall !== 1'b0 || issue_valid !== 1'b0 || issue_rob_id !== 3'd0)
      begin errors++; $display("FAIL jalr_reset got stall=%b v=%b id=%0d exp stall=0 v=0 id=0", fetch_stall, issue_valid, issue_rob_id); end
  endtask
  task automatic test_rob_same_cycle();
    do_reset();
    in_valid = 1; in_type = OP_LUI;
    for (int i = 0; i < 7; i++) tick();
    checks++; if (issue_valid !== 1'b1 || issue_to_rs !== 1'b0 || issue_to_lsb !== 1'b0 || issue_rob_id !== 3'd6)
      begin errors++; $display("FAIL rob_lui got v=%b rs=%b lsb=%b id=%0d exp v=1 rs=0 lsb=0 id=6", issue_valid, issue_to_rs, issue_to_lsb, issue_rob_id); end
    rob_release = 1;
    tick();
    rob_release = 0;
    #1;
    checks++; if (in_ready !== 1'b1 || issue_rob_id !== 3'd7)
      begin errors++; $display("FAIL rob_net_zero got ready=%b id=%0d exp ready=1 id=7", in_ready, issue_rob_id); end
    tick();
    checks++; if (issue_valid !== 1'b1 || issue_rob_id !== 3'd0 || in_ready !== 1'b0)
      begin errors++; $display("FAIL rob_last got v=%b id=%0d ready=%b exp v=1 id=0 ready=0", issue_valid, issue_rob_id, in_ready); end
    in_valid = 0;
  endtask
  task automatic test_clear();
    do_reset();
    in_valid = 1; in_type = OP_ADDI;
    for (int i = 0; i < 5; i++) tick();
    clear = 1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clear_ready got %b exp 0", in_ready); end
    tick();
    clear = 0;
    checks++; if (issue_valid !== 1'b0 || fetch_stall !== 1'b1 || in_ready !== 1'b0)
      begin errors++; $display("FAIL clear_flush got v=%b stall=%b ready=%b exp v=0 stall=1 ready=0", issue_valid, fetch_stall, in_ready); end
    tick();
    checks++; if (fetch_stall !== 1'b0 || issue_valid !== 1'b0)
      begin errors++; $display("FAIL clear_run got stall=%b v=%b exp stall=0 v=0", fetch_stall, issue_valid); end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (issue_valid !== 1'b1 || issue_rob_id !== 3'(i))
        begin errors++; $display("FAIL clear_reissue%0d got v=%b id=%0d exp v=1 id=%0d", i, issue_valid, issue_rob_id, i); end
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clear_full got %b exp 0", in_ready); end
    in_valid = 0;
  endtask
  task automatic test_rdy_freeze();
    do_reset();
    in_valid = 1; in_type = OP_ADDI;
    for (int i = 0; i < 3; i++) tick();
    rdy = 0;
    for (int i = 0; i < 4; i++) begin
      rob_release = i[0]; rs_release = ~i[0]; lsb_release = i[0];
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rdy_ready%0d got %b exp 0", i, in_ready); end
      tick();
      checks++; if (issue_valid !== 1'b1 || issue_to_rs !== 1'b1 || issue_rob_id !== 3'd2 || fetch_stall !== 1'b0)
        begin errors++; $display("FAIL rdy_hold%0d got v=%b rs=%b id=%0d stall=%b exp v=1 rs=1 id=2 stall=0", i, issue_valid, issue_to_rs, issue_rob_id, fetch_stall); end
    end
    rdy = 1; rob_release = 0; rs_release = 0; lsb_release = 0;
    for (int i = 3; i < 8; i++) begin
      tick();
      checks++; if (issue_valid !== 1'b1 || issue_rob_id !== 3'(i))
        begin errors++; $display("FAIL rdy_resume%0d got v=%b id=%0d exp v=1 id=%0d", i, issue_valid, issue_rob_id, i); end
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rdy_full got %b exp 0", in_ready); end
    in_valid = 0;
  endtask
  initial begin
    test_reset();
    test_fill_rs();
    test_lsb();
    test_jalr();
    test_rob_same_cycle();
    test_clear();
    test_rdy_freeze();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Credit-based issue controller between the decode stage and the out-of-order back end (RoB, RS, LSB). Decides each cycle whether the pending decoded instruction may issue, steers it to the RS or the LSB, allocates its RoB tail index, and tracks free entries in all three structures through issue/release counters. It also serialises JALR issue on an unresolved rs1 and runs a one-cycle recovery sequence on pipeline clear.

## Interface
Parameters:
- ROB_DEPTH, 8, RoB entries (power of two); ROB_W = log2(ROB_DEPTH)
- RS_DEPTH, 8, RS entries
- LSB_DEPTH, 8, LSB entries

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes all state
- clear  in  1  pipeline flush (branch mispredict)
- in_valid  in  1  decoded instruction pending
- in_type  in  7  opcode field instr[6:0]
- in_dep1  in  1  rs1 has an outstanding producer
- in_ready  out  1  combinational accept; transfer when in_valid && in_ready
- issue_valid  out  1  registered one-cycle issue strobe
- issue_to_rs  out  1  issued instruction occupies an RS entry
- issue_to_lsb  out  1  issued instruction occupies an LSB entry
- issue_rob_id  out  ROB_W  RoB index allocated to it
- rob_release  in  1  RoB head committed (frees one entry)
- rs_release  in  1  one RS entry freed
- lsb_release  in  1  one LSB entry freed
- fetch_stall  out  1  high while in JALR_WAIT or FLUSH

## Operation
- Class from in_type: LD_TYPE/S_TYPE → LSB; LUI/AUIPC/JAL → RoB only; all other opcodes → RS. Every instruction takes one RoB entry.
- Credits: rob_free (0..ROB_DEPTH), rs_free, lsb_free; width log2(DEPTH)+1. Reset/flush value = DEPTH.
- need_ok = rob_free>0 && (class RS → rs_free>0) && (class LSB → lsb_free>0).
- in_ready = rdy && !clear && state==RUN && need_ok && !(in_type==JALR && in_dep1).
- On transfer: decrement the class credit and rob_free; issue_rob_id <= tail; tail <= tail+1 (wraps modulo ROB_DEPTH).
- Release: increment corresponding credit. Same-cycle issue + release on one counter: net unchanged. Release at DEPTH: saturate, flag assertion failure.
- FSM:
  - RUN: normal. in_valid && JALR && in_dep1 → JALR_WAIT.
  - JALR_WAIT: in_ready=0, fetch_stall=1. When in_dep1 falls → RUN (issue on a following cycle via normal path).
  - FLUSH: one cycle. rob_free/rs_free/lsb_free ← DEPTH, tail ← 0, releases ignored, in_ready=0 → RUN.
  - clear in any state → FLUSH next cycle (highest priority; same-cycle transfer suppressed).
- rdy=0: no state, credit or register change; in_ready=0; issue_valid holds its value.

## Timing
- Reset: issue_valid=0, issue_to_rs=0, issue_to_lsb=0, issue_rob_id=0, fetch_stall=0, state RUN, tail=0, credits at DEPTH.
- Latency: transfer in cycle N → issue_valid=1 in cycle N+1 only (one cycle per transfer); issue_valid=0 otherwise.
- Release in cycle N visible in in_ready at N+1.
- Throughput: one issue per cycle while credits remain.
- Back-to-back full: after the last credit is taken, in_ready=0 until a release is registered.
- Reset mid-flush or mid-JALR_WAIT: returns to the reset state above.

## Structure
- Shared package/config: opcode constants (LUI, AUIPC, JAL, JALR, B_TYPE, LD_TYPE, S_TYPE, I_TYPE, R_TYPE), ROB_SIZE_WIDTH, state encoding (RUN, JALR_WAIT, FLUSH), class encoding.
- One sub-module: credit_counter (parameter DEPTH; ports take, give, reload; output free, nonzero) instantiated three times.

## Test plan
- Reset, then 8 consecutive ADDI (in_valid=1, no releases) → 8 issue_valid pulses, issue_rob_id 0..7, in_ready=0 on the 9th cycle (rob_free=0, rs_free=0).
- 8 loads issued, LSB full, then ADD pending → ADD issues immediately with issue_to_rs=1; a 9th load stalls until lsb_release, then issues the cycle after.
- JALR with in_dep1=1 for 3 cycles → fetch_stall=1, no issue; in_dep1 falls → JALR issues, issue_to_rs=1, fetch_stall=0.
- rob_free=1 with simultaneous transfer and rob_release → rob_free stays 1, in_ready stays 1 next cycle.
- clear asserted with in_valid=1, 5 entries outstanding → no issue that cycle, fetch_stall=1 next cycle, then next issue gets issue_rob_id=0 and all credits = 8.
- rdy=0 for 4 cycles mid-stream with releases toggling → credits, tail and outputs unchanged; resumes exactly where stopped.
